// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Memory-side handshake bundle for instr_sequencer.
//               Carries the instruction-fetch channel (req/ready/data) and
//               the data-memory access channel (req/ready).
//               master : sequencer side (drives requests)
//               slave  : memory side   (drives ready and instruction data)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int DATA_W = 16
) ();
    logic              imem_req;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_data;
    logic              dmem_req;
    logic              dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        input  imem_data,
        output dmem_req,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output imem_data,
        input  dmem_req,
        output dmem_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute sequencer in front of the
//               control unit. Fetches instruction (and literal) words,
//               qualifies the control word with cw_valid/phase and sequences
//               data-memory cycles; flags a sticky memory timeout.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               mem_if (master) - imem req/ready/data, dmem req/ready
//               stall_i         - hazard hold, only honoured in EXEC
//               pc_inc_o        - one-cycle PC advance pulse
//               ir_o, lit_o     - instruction and literal registers
//               cw_valid_o      - control word may commit this cycle
//               phase_o         - 0 = EX0, 1 = EX1 (memory phase)
//               err_o           - sticky memory-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    instr_sequencer_if.master      mem_if,
    input  wire logic              stall_i,
    output logic                   pc_inc_o,
    output logic [DATA_W-1:0]      ir_o,
    output logic [DATA_W-1:0]      lit_o,
    output logic                   cw_valid_o,
    output logic [1:0]             phase_o,
    output logic                   err_o
);

    localparam logic [2:0] c_FETCH     = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_LIT_FETCH = 3'd2;
    localparam logic [2:0] c_EXEC      = 3'd3;
    localparam logic [2:0] c_MEM       = 3'd4;
    localparam logic [2:0] c_ERR       = 3'd5;

    localparam logic [7:0] c_MAX_WAIT  = 8'(MAX_WAIT);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] lit_q, lit_d;
    logic [7:0]        wait_q, wait_d;
    logic              pc_inc_q, pc_inc_d;

    logic              w_two_word;
    logic              w_mem_op;
    logic              w_waiting;
    logic              w_imem_req;
    logic              w_dmem_req;

    // Instruction class decode on the latched IR.
    always_comb begin
        w_two_word = (ir_q[15:9] == 7'b10_00010) || (ir_q[15:9] == 7'b10_01110);
        w_mem_op   = 1'b0;
        if (ir_q[15:14] == 2'b10) begin
            case (ir_q[13:9])
                5'b00000, 5'b00001, 5'b00100,
                5'b00101, 5'b01110, 5'b01111: w_mem_op = 1'b1;
                default:                      w_mem_op = 1'b0;
            endcase
        end
        if ((ir_q[15:11] == 5'b10100) || (ir_q[15:11] == 5'b10101)) begin
            w_mem_op = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_FETCH;
            ir_q     <= '0;
            lit_q    <= '0;
            wait_q   <= '0;
            pc_inc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            lit_q    <= lit_d;
            wait_q   <= wait_d;
            pc_inc_q <= pc_inc_d;
        end
    end

    // Next-state logic. A request that reaches MAX_WAIT without ready goes
    // to ERR, but a ready arriving in that same cycle still completes.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        lit_d     = lit_q;
        pc_inc_d  = 1'b0;
        w_waiting = 1'b0;
        case (state_q)
            c_FETCH: begin
                if (mem_if.imem_ready) begin
                    ir_d     = mem_if.imem_data;
                    pc_inc_d = 1'b1;
                    state_d  = c_DECODE;
                end else if (wait_q == c_MAX_WAIT) begin
                    state_d  = c_ERR;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            c_DECODE: begin
                state_d = w_two_word ? c_LIT_FETCH : c_EXEC;
            end
            c_LIT_FETCH: begin
                if (mem_if.imem_ready) begin
                    lit_d    = mem_if.imem_data;
                    pc_inc_d = 1'b1;
                    state_d  = c_EXEC;
                end else if (wait_q == c_MAX_WAIT) begin
                    state_d  = c_ERR;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            c_EXEC: begin
                if (!stall_i) begin
                    state_d = w_mem_op ? c_MEM : c_FETCH;
                end
            end
            c_MEM: begin
                if (mem_if.dmem_ready) begin
                    state_d = c_FETCH;
                end else if (wait_q == c_MAX_WAIT) begin
                    state_d = c_ERR;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            c_ERR: begin
                state_d = c_ERR;
            end
            default: begin
                state_d = c_FETCH;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (w_waiting) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Output decode. Control outputs are forced low while rst is held so
    // that a request never appears until the cycle after reset releases.
    always_comb begin
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        cw_valid_o = 1'b0;
        phase_o    = 2'd0;
        err_o      = 1'b0;
        if (!rst) begin
            case (state_q)
                c_FETCH, c_LIT_FETCH: w_imem_req = 1'b1;
                c_EXEC:               cw_valid_o = !stall_i;
                c_MEM: begin
                    w_dmem_req = 1'b1;
                    phase_o    = 2'd1;
                    cw_valid_o = mem_if.dmem_ready;
                end
                c_ERR:                err_o = 1'b1;
                default:              w_imem_req = 1'b0;
            endcase
        end
    end

    assign mem_if.imem_req = w_imem_req;
    assign mem_if.dmem_req = w_dmem_req;
    assign pc_inc_o        = pc_inc_q && !rst;
    assign ir_o            = ir_q;
    assign lit_o           = lit_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. A step-queue model
//               predicts every output each cycle; directed sequences pin the
//               model with hand-computed values, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int MAX_WAIT = 4;

    // Step codes for the behavioural model's per-instruction step queue.
    localparam int S_F = 0;  // fetch instruction word
    localparam int S_D = 1;  // decode
    localparam int S_L = 2;  // fetch literal word
    localparam int S_X = 3;  // execute (EX0)
    localparam int S_M = 4;  // memory phase (EX1)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_inc;
    logic [15:0] ir, lit;
    logic        cw_valid, err;
    logic [1:0]  phase;

    instr_sequencer_if #(.DATA_W(16)) bus ();

    instr_sequencer #(.DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_if     (bus),
        .stall_i    (stall),
        .pc_inc_o   (pc_inc),
        .ir_o       (ir),
        .lit_o      (lit),
        .cw_valid_o (cw_valid),
        .phase_o    (phase),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    // Model state
    int          q[$];
    bit          m_err  = 1'b0;
    int          m_wait = 0;
    bit          m_pc   = 1'b0;
    logic [15:0] m_ir   = 16'h0;
    logic [15:0] m_lit  = 16'h0;

    // Expected outputs for the current cycle
    logic        e_ireq, e_dreq, e_cwv, e_pc, e_err;
    logic [1:0]  e_ph;
    logic [15:0] e_ir, e_lit;

    function automatic bit is_two(input logic [15:0] w);
        return (w[15:9] == 7'b1000010) || (w[15:9] == 7'b1001110);
    endfunction

    function automatic bit is_mem(input logic [15:0] w);
        logic [6:0] op7;
        logic [4:0] op5;
        op7 = w[15:9];
        op5 = w[15:11];
        return (op7 inside {7'b1000000, 7'b1000001, 7'b1000100,
                            7'b1000101, 7'b1001110, 7'b1001111})
            || (op5 inside {5'b10100, 5'b10101});
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_eval(input bit r, input bit dr, input bit st);
        e_ireq = 0; e_dreq = 0; e_cwv = 0; e_pc = 0; e_err = 0; e_ph = 2'd0;
        e_ir   = m_ir;
        e_lit  = m_lit;
        if (!r) begin
            e_pc = m_pc;
            if (m_err) begin
                e_err = 1;
            end else begin
                case (q[0])
                    S_F, S_L: e_ireq = 1;
                    S_X:      e_cwv  = !st;
                    S_M: begin
                        e_dreq = 1;
                        e_ph   = 2'd1;
                        e_cwv  = dr;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_step(input bit r, input bit irdy, input logic [15:0] id,
                              input bit dr, input bit st);
        bit done;
        bit waiting;
        int head;
        done = 0;
        waiting = 0;
        if (r) begin
            q.delete();
            q.push_back(S_F);
            m_ir = 16'h0; m_lit = 16'h0; m_err = 0; m_wait = 0; m_pc = 0;
            return;
        end
        m_pc = 0;
        if (m_err) return;
        head = q[0];
        case (head)
            S_F: if (irdy) begin
                     m_ir = id; m_pc = 1; done = 1;
                 end else waiting = 1;
            S_L: if (irdy) begin
                     m_lit = id; m_pc = 1; done = 1;
                 end else waiting = 1;
            S_D: done = 1;
            S_X: done = !st;
            S_M: if (dr) done = 1; else waiting = 1;
            default: done = 1;
        endcase
        if (done) begin
            void'(q.pop_front());
            m_wait = 0;
            if (head == S_F) begin
                q.push_back(S_D);
                if (is_two(m_ir)) q.push_back(S_L);
                q.push_back(S_X);
                if (is_mem(m_ir)) q.push_back(S_M);
            end
            if (q.size() == 0) q.push_back(S_F);
        end else if (waiting) begin
            if (m_wait == MAX_WAIT) begin
                m_err  = 1;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    // One clock cycle: drive inputs after the edge, predict, reach negedge, advance.
    task automatic cyc(input bit r, input bit irdy, input logic [15:0] id,
                       input bit dr, input bit st);
        @(posedge clk);
        #1;
        rst            = r;
        bus.imem_ready = irdy;
        bus.imem_data  = id;
        bus.dmem_ready = dr;
        stall          = st;
        model_eval(r, dr, st);
        @(negedge clk);
        model_step(r, irdy, id, dr, st);
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", {15'd0, bus.imem_req}, {15'd0, e_ireq});
            chk("dmem_req", {15'd0, bus.dmem_req}, {15'd0, e_dreq});
            chk("cw_valid", {15'd0, cw_valid},     {15'd0, e_cwv});
            chk("pc_inc",   {15'd0, pc_inc},       {15'd0, e_pc});
            chk("err",      {15'd0, err},          {15'd0, e_err});
            chk("phase",    {14'd0, phase},        {14'd0, e_ph});
            chk("IR",       ir,                    e_ir);
            chk("LIT",      lit,                   e_lit);
        end
    end

    logic [15:0] words [11] = '{16'h844A, 16'h9C00, 16'h884A, 16'h8000, 16'h8200,
                                16'h8A00, 16'h9E00, 16'hA000, 16'hA800, 16'h0901,
                                16'h6048};

    initial begin
        bus.imem_ready = 0;
        bus.imem_data  = 16'h0;
        bus.dmem_ready = 0;

        cyc(1, 0, 16'h0, 0, 0);
        chk_en = 1;
        cyc(1, 0, 16'h0, 0, 0);
        chk("reset imem_req", {15'd0, bus.imem_req}, 16'd0);
        chk("reset IR", ir, 16'h0000);

        // ADDI, zero wait: req cyc1, decode cyc2, commit cyc3, fetch cyc4
        cyc(0, 1, 16'h0901, 0, 0);
        chk("t1 c1 imem_req", {15'd0, bus.imem_req}, 16'd1);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t1 c2 pc_inc", {15'd0, pc_inc}, 16'd1);
        chk("t1 c2 IR", ir, 16'h0901);
        chk("t1 c2 imem_req", {15'd0, bus.imem_req}, 16'd0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t1 c3 cw_valid", {15'd0, cw_valid}, 16'd1);
        chk("t1 c3 pc_inc", {15'd0, pc_inc}, 16'd0);

        // LRLI + literal
        cyc(0, 1, 16'h844A, 0, 0);
        chk("t1 c4 imem_req", {15'd0, bus.imem_req}, 16'd1);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t2 decode pc_inc", {15'd0, pc_inc}, 16'd1);
        cyc(0, 1, 16'h1234, 0, 0);
        chk("t2 litfetch req", {15'd0, bus.imem_req}, 16'd1);
        chk("t2 litfetch cw", {15'd0, cw_valid}, 16'd0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t2 exec LIT", lit, 16'h1234);
        chk("t2 exec pc_inc", {15'd0, pc_inc}, 16'd1);
        chk("t2 exec cw", {15'd0, cw_valid}, 16'd1);

        // LDR, dmem_ready delayed 3 cycles
        cyc(0, 1, 16'h884A, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t3 exec cw", {15'd0, cw_valid}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'hFFFF, 0, 0);
            chk("t3 wait dmem_req", {15'd0, bus.dmem_req}, 16'd1);
            chk("t3 wait phase", {14'd0, phase}, 16'd1);
            chk("t3 wait cw", {15'd0, cw_valid}, 16'd0);
        end
        cyc(0, 1, 16'hFFFF, 1, 0);
        chk("t3 ready dmem_req", {15'd0, bus.dmem_req}, 16'd1);
        chk("t3 ready cw", {15'd0, cw_valid}, 16'd1);

        // INC with a 2-cycle stall
        cyc(0, 1, 16'h6048, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 16'hFFFF, 0, 1);
            chk("t4 stall cw", {15'd0, cw_valid}, 16'd0);
        end
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t4 commit cw", {15'd0, cw_valid}, 16'd1);
        chk("t4 IR", ir, 16'h6048);

        // Instruction fetch timeout
        for (int i = 0; i <= MAX_WAIT; i++) begin
            cyc(0, 0, 16'hFFFF, 0, 0);
            chk("t5 wait imem_req", {15'd0, bus.imem_req}, 16'd1);
        end
        cyc(0, 1, 16'hFFFF, 1, 0);
        chk("t5 err", {15'd0, err}, 16'd1);
        chk("t5 err imem_req", {15'd0, bus.imem_req}, 16'd0);
        cyc(0, 1, 16'hFFFF, 1, 0);
        chk("t5 err sticky", {15'd0, err}, 16'd1);
        cyc(1, 0, 16'hFFFF, 0, 0);

        // Reset during a memory wait
        cyc(0, 1, 16'h884A, 0, 0);
        chk("t5 resume req", {15'd0, bus.imem_req}, 16'd1);
        chk("t5 resume err", {15'd0, err}, 16'd0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0);
        chk("t6 mem dmem_req", {15'd0, bus.dmem_req}, 16'd1);
        cyc(1, 1, 16'hFFFF, 1, 0);
        chk("t6 rst dmem_req", {15'd0, bus.dmem_req}, 16'd0);
        chk("t6 rst cw", {15'd0, cw_valid}, 16'd0);
        cyc(0, 0, 16'hFFFF, 0, 0);
        chk("t6 after IR", ir, 16'h0000);
        chk("t6 after imem_req", {15'd0, bus.imem_req}, 16'd1);
        chk("t6 after dmem_req", {15'd0, bus.dmem_req}, 16'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          r, irdy, dr, st;
            logic [15:0] id;
            r    = ($urandom_range(0, 199) == 0) || (m_err && ($urandom_range(0, 7) == 0));
            irdy = ($urandom_range(0, 9) < 6);
            dr   = ($urandom_range(0, 9) < 6);
            st   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0)
                id = words[$urandom_range(0, 10)];
            else
                id = 16'($urandom);
            cyc(r, irdy, id, dr, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
